// File: rtl/msx_bus_initiator.sv
// MSX slot-bus initiator: turns single-beat memory/I-O requests into Z80-timed
// strobes on a divided T-state clock, honouring WAIT_n with a timeout.
module msx_bus_initiator #(
  parameter int CLK_DIV      = 30,
  parameter int WAIT_TIMEOUT = 1024,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        CLK_BASE,
  input  logic        RESET_n,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic        REQ_IO,
  input  logic        REQ_SLOT,
  input  logic [15:0] REQ_ADDR,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic        RSP_TIMEOUT,
  output logic        INT_PENDING,
  output logic        BUS_CLOCK,
  output logic [15:0] BUS_A,
  output logic [7:0]  BUS_D_OUT,
  output logic        BUS_D_OE,
  input  logic [7:0]  BUS_D_IN,
  output logic        BUS_MREQ_n,
  output logic        BUS_IORQ_n,
  output logic        BUS_RD_n,
  output logic        BUS_WR_n,
  output logic        BUS_SLTSL_n,
  input  logic        BUS_WAIT_n,
  input  logic        BUS_INT_n,
  input  logic        BUS_BUSDIR_n
);
  localparam int CNT_W  = $clog2(CLK_DIV);
  localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_FALL = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLK_DIV / 2);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_START, S_T1, S_T2, S_TW, S_T3} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               bus_clock_q, bus_clock_d, ready_q, ready_d, abort_q, abort_d;
  logic [15:0]        bus_a_q, bus_a_d, addr_q, addr_d;
  logic [7:0]         d_out_q, d_out_d, wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic               d_oe_q, d_oe_d, mreq_n_q, mreq_n_d, iorq_n_q, iorq_n_d;
  logic               rd_n_q, rd_n_d, wr_n_q, wr_n_d, sltsl_n_q, sltsl_n_d;
  logic               rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
  logic               write_q, write_d, io_q, io_d, slot_q, slot_d;
  logic [SYNC_STAGES-1:0] wait_sync_q, wait_sync_d, int_sync_q, int_sync_d;
  logic [SYNC_STAGES-1:0] busdir_sync_q, busdir_sync_d;
  logic               rise, fall, wait_s, sample_wait, unused_busdir;

  // Events are decoded one CLK early so registered strobes move with BUS_CLOCK edges.
  assign rise   = (cnt_q == CNT_LAST);
  assign fall   = (cnt_q == CNT_FALL);
  assign wait_s = wait_sync_q[SYNC_STAGES-1];
  // BUSDIR is only synchronized; reads complete whatever its level.
  assign unused_busdir = busdir_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = rise ? '0 : cnt_q + 1'b1;
    bus_clock_d   = (cnt_d < CNT_HALF);
    wait_cnt_d    = wait_cnt_q;
    ready_d       = 1'b0;
    abort_d       = abort_q;
    bus_a_d       = bus_a_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    write_d       = write_q;
    io_d          = io_q;
    slot_d        = slot_q;
    d_out_d       = d_out_q;
    d_oe_d        = d_oe_q;
    mreq_n_d      = mreq_n_q;
    iorq_n_d      = iorq_n_q;
    rd_n_d        = rd_n_q;
    wr_n_d        = wr_n_q;
    sltsl_n_d     = sltsl_n_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    sample_wait   = 1'b0;
    wait_sync_d   = (wait_sync_q << 1) | SYNC_STAGES'(BUS_WAIT_n);
    int_sync_d    = (int_sync_q << 1) | SYNC_STAGES'(BUS_INT_n);
    busdir_sync_d = (busdir_sync_q << 1) | SYNC_STAGES'(BUS_BUSDIR_n);

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (REQ_VALID && ready_q) begin
          ready_d = 1'b0;
          state_d = S_START;
          addr_d  = REQ_ADDR;
          wdata_d = REQ_WDATA;
          write_d = REQ_WRITE;
          io_d    = REQ_IO;
          slot_d  = REQ_SLOT;
        end
      end
      S_START: begin
        if (rise) begin
          state_d    = S_T1;
          bus_a_d    = addr_q;
          wait_cnt_d = '0;
          abort_d    = 1'b0;
        end
      end
      S_T1: begin
        if (fall) begin
          state_d = S_T2;
          if (!io_q) begin
            mreq_n_d  = 1'b0;
            sltsl_n_d = ~slot_q;
            rd_n_d    = write_q;
          end
          if (write_q) begin
            d_oe_d  = 1'b1;
            d_out_d = wdata_q;
          end
        end
      end
      S_T2: begin
        if (rise && io_q) begin
          iorq_n_d = 1'b0;
          rd_n_d   = write_q;
          wr_n_d   = ~write_q;
        end
        if (fall) begin
          // I/O cycles always get one TW that neither samples WAIT_n nor counts.
          if (io_q) begin
            state_d = S_TW;
          end else begin
            wr_n_d      = ~write_q;
            sample_wait = 1'b1;
          end
        end
      end
      S_TW: begin
        if (fall) sample_wait = 1'b1;
      end
      S_T3: begin
        if (rise) rsp_rdata_d = (write_q || abort_q) ? 8'hFF : BUS_D_IN;
        if (fall) begin
          state_d       = S_IDLE;
          mreq_n_d      = 1'b1;
          iorq_n_d      = 1'b1;
          rd_n_d        = 1'b1;
          wr_n_d        = 1'b1;
          sltsl_n_d     = 1'b1;
          d_oe_d        = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = abort_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (sample_wait) begin
      if (wait_s) begin
        state_d = S_T3;
      end else if (wait_cnt_q == WCNT_MAX) begin
        state_d = S_T3;
        abort_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        state_d    = S_TW;
      end
    end
  end

  always_ff @(posedge CLK_BASE or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bus_clock_q   <= 1'b1;
      wait_cnt_q    <= '0;
      ready_q       <= 1'b0;
      abort_q       <= 1'b0;
      bus_a_q       <= '0;
      d_out_q       <= '0;
      d_oe_q        <= 1'b0;
      mreq_n_q      <= 1'b1;
      iorq_n_q      <= 1'b1;
      rd_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      sltsl_n_q     <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      wait_sync_q   <= '1;
      int_sync_q    <= '1;
      busdir_sync_q <= '1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bus_clock_q   <= bus_clock_d;
      wait_cnt_q    <= wait_cnt_d;
      ready_q       <= ready_d;
      abort_q       <= abort_d;
      bus_a_q       <= bus_a_d;
      d_out_q       <= d_out_d;
      d_oe_q        <= d_oe_d;
      mreq_n_q      <= mreq_n_d;
      iorq_n_q      <= iorq_n_d;
      rd_n_q        <= rd_n_d;
      wr_n_q        <= wr_n_d;
      sltsl_n_q     <= sltsl_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      wait_sync_q   <= wait_sync_d;
      int_sync_q    <= int_sync_d;
      busdir_sync_q <= busdir_sync_d;
    end
  end

  // Request fields are plain data holding registers.
  always_ff @(posedge CLK_BASE) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    write_q <= write_d;
    io_q    <= io_d;
    slot_q  <= slot_d;
  end

  assign REQ_READY   = ready_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_RDATA   = rsp_rdata_q;
  assign RSP_TIMEOUT = rsp_timeout_q;
  assign INT_PENDING = ~int_sync_q[SYNC_STAGES-1];
  assign BUS_CLOCK   = bus_clock_q;
  assign BUS_A       = bus_a_q;
  assign BUS_D_OUT   = d_out_q;
  assign BUS_D_OE    = d_oe_q;
  assign BUS_MREQ_n  = mreq_n_q;
  assign BUS_IORQ_n  = iorq_n_q;
  assign BUS_RD_n    = rd_n_q;
  assign BUS_WR_n    = wr_n_q;
  assign BUS_SLTSL_n = sltsl_n_q;
endmodule

// File: tb/tb_msx_bus_initiator.sv
// Bench for msx_bus_initiator: directed table, random transactions against a
// T-state timeline model, plus reset and interrupt sequences.
`timescale 1ns/1ps
module tb_msx_bus_initiator;
  localparam int CLK_DIV = 30;
  localparam int WTO     = 4;

  logic        CLK_BASE = 1'b0, RESET_n = 1'b0;
  logic        REQ_VALID = 1'b0, REQ_WRITE = 1'b0, REQ_IO = 1'b0, REQ_SLOT = 1'b0;
  logic [15:0] REQ_ADDR = '0;
  logic [7:0]  REQ_WDATA = '0, BUS_D_IN = '0;
  logic        BUS_WAIT_n = 1'b1, BUS_INT_n = 1'b1, BUS_BUSDIR_n = 1'b1;
  logic        REQ_READY, RSP_VALID, RSP_TIMEOUT, INT_PENDING, BUS_CLOCK, BUS_D_OE;
  logic [7:0]  RSP_RDATA, BUS_D_OUT;
  logic [15:0] BUS_A;
  logic        BUS_MREQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_SLTSL_n;

  always #5 CLK_BASE = ~CLK_BASE;

  msx_bus_initiator #(.CLK_DIV(CLK_DIV), .WAIT_TIMEOUT(WTO), .SYNC_STAGES(2)) dut (
    .CLK_BASE(CLK_BASE), .RESET_n(RESET_n),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE), .REQ_IO(REQ_IO),
    .REQ_SLOT(REQ_SLOT), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_TIMEOUT(RSP_TIMEOUT),
    .INT_PENDING(INT_PENDING), .BUS_CLOCK(BUS_CLOCK), .BUS_A(BUS_A),
    .BUS_D_OUT(BUS_D_OUT), .BUS_D_OE(BUS_D_OE), .BUS_D_IN(BUS_D_IN),
    .BUS_MREQ_n(BUS_MREQ_n), .BUS_IORQ_n(BUS_IORQ_n), .BUS_RD_n(BUS_RD_n),
    .BUS_WR_n(BUS_WR_n), .BUS_SLTSL_n(BUS_SLTSL_n), .BUS_WAIT_n(BUS_WAIT_n),
    .BUS_INT_n(BUS_INT_n), .BUS_BUSDIR_n(BUS_BUSDIR_n)
  );

  // Clock edges since reset release; the divider count after edge n is n mod CLK_DIV.
  int unsigned cyc;
  always @(posedge CLK_BASE or negedge RESET_n)
    if (!RESET_n) cyc <= 0;
    else          cyc <= cyc + 1;

  int          n_vec = 0, n_bad = 0;
  logic [15:0] last_addr = '0;

  typedef struct {
    logic wr; logic io; logic slot;
    logic [15:0] addr; logic [7:0] wdata; logic [7:0] din;
    int k; logic to; logic [7:0] exp_rdata; int exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {BUS_CLOCK, MREQ, IORQ, RD, WR, SLTSL, D_OE, RSP_VALID, REQ_READY}
  // r = edges since the start RISE, lat = edge of the T3 FALL.
  function automatic logic [8:0] exp_ctrl(int r, logic wr, logic io, logic slot, int lat,
                                          int unsigned c);
    logic act_mem, act_io;
    act_mem = !io && r >= 15 && r < lat;
    act_io  = io && r >= 30 && r < lat;
    return {((c % CLK_DIV) < CLK_DIV / 2),
            !act_mem,
            !act_io,
            !((act_mem || act_io) && !wr),
            !(wr && r < lat && (io ? r >= 30 : r >= 45)),
            !(act_mem && slot),
            (wr && r >= 15 && r < lat),
            (r == lat),
            (r > lat)};
  endfunction

  function automatic logic [8:0] act_ctrl();
    return {BUS_CLOCK, BUS_MREQ_n, BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_SLTSL_n,
            BUS_D_OE, RSP_VALID, REQ_READY};
  endfunction

  task automatic wait_ready(input string name);
    int guard;
    guard = 0;
    @(negedge CLK_BASE);
    while (!REQ_READY && guard < 300) begin
      @(negedge CLK_BASE);
      guard++;
    end
    chk(name, REQ_READY, 1'b1);
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int acc, s, r, rel, rv_at, bad_r;
    logic [63:0] ta, te, a_w, e_w;
    logic [8:0] ec;
    logic [7:0] rd_got;
    logic to_got, bad;
    BUS_D_IN = v.din;
    BUS_WAIT_n = 1'b0;
    rel = v.to ? 1000000 : (v.io ? 60 + 30 * v.k : 30 + 30 * v.k);
    wait_ready($sformatf("ready[%0d]", idx));
    REQ_WRITE = v.wr; REQ_IO = v.io; REQ_SLOT = v.slot;
    REQ_ADDR = v.addr; REQ_WDATA = v.wdata; REQ_VALID = 1'b1;
    @(posedge CLK_BASE);
    #1;
    acc = int'(cyc);
    s = (acc / CLK_DIV + 1) * CLK_DIV;
    rv_at = -1; rd_got = 'x; to_got = 'x; bad = 1'b0; bad_r = 0; ta = '0; te = '0;
    r = acc - s;
    while (r <= v.exp_lat + 1) begin
      @(negedge CLK_BASE);
      REQ_VALID = 1'b0;
      r = int'(cyc) - s;
      ec  = exp_ctrl(r, v.wr, v.io, v.slot, v.exp_lat, cyc);
      e_w = {31'd0, ec, (r >= 0 ? v.addr : last_addr), (ec[2] ? v.wdata : 8'h00)};
      a_w = {31'd0, act_ctrl(), BUS_A, (ec[2] ? BUS_D_OUT : 8'h00)};
      if (!bad) begin
        ta = a_w; te = e_w;
        if (a_w !== e_w) begin bad = 1'b1; bad_r = r; end
      end
      if (RSP_VALID && rv_at < 0) begin
        rv_at = r; rd_got = RSP_RDATA; to_got = RSP_TIMEOUT;
      end
      if (r == rel) BUS_WAIT_n = 1'b1;
    end
    chk($sformatf("trace[%0d] r=%0d", idx, bad_r), ta, te);
    chk($sformatf("latency[%0d]", idx), 64'(rv_at), 64'(v.exp_lat));
    chk($sformatf("rdata[%0d]", idx), {56'd0, rd_got}, {56'd0, v.exp_rdata});
    chk($sformatf("timeout[%0d]", idx), {63'd0, to_got}, {63'd0, v.to});
    BUS_WAIT_n = 1'b1;
    last_addr = v.addr;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    vec_t v;
    int acc, s, guard;
    logic seen;

    // wr io slot addr wdata din k to exp_rdata exp_lat
    tbl[0] = '{1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 8'h5A, 0, 1'b0, 8'h5A, 75};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 16'h8001, 8'hC3, 8'h00, 0, 1'b0, 8'hFF, 75};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'h0098, 8'h00, 8'h12, 0, 1'b0, 8'h12, 105};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'h4123, 8'h00, 8'hA7, 3, 1'b0, 8'hA7, 165};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h7FFF, 8'h00, 8'h99, 0, 1'b1, 8'hFF, 75 + 30 * WTO};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h3C, 0, 1'b0, 8'h3C, 75};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 16'h0099, 8'h55, 8'h00, 1, 1'b0, 8'hFF, 135};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h00, 2, 1'b0, 8'hFF, 135};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'h00A8, 8'h00, 8'hE1, 0, 1'b0, 8'hE1, 105};

    // Reset state
    #23;
    chk("reset_outputs", {act_ctrl(), BUS_A, RSP_RDATA, RSP_TIMEOUT},
        {9'b1_11111_0_0_0, 16'h0000, 8'h00, 1'b0});
    @(negedge CLK_BASE);
    RESET_n = 1'b1;
    #1 chk("ready_held_after_release", REQ_READY, 1'b0);
    @(negedge CLK_BASE);
    chk("ready_first_clk", REQ_READY, 1'b1);

    // Interrupt synchronizer: two CLKs to propagate each way
    BUS_INT_n = 1'b0;
    @(negedge CLK_BASE); chk("int_1clk", INT_PENDING, 1'b0);
    @(negedge CLK_BASE); chk("int_2clk", INT_PENDING, 1'b1);
    BUS_INT_n = 1'b1;
    @(negedge CLK_BASE); chk("int_hold", INT_PENDING, 1'b1);
    @(negedge CLK_BASE); chk("int_clear", INT_PENDING, 1'b0);

    for (int i = 0; i < 9; i++) run_txn(i, tbl[i]);

    for (int i = 0; i < 24; i++) begin
      v.wr = 1'($urandom); v.io = 1'($urandom); v.slot = 1'($urandom);
      v.addr = 16'($urandom); v.wdata = 8'($urandom); v.din = 8'($urandom);
      v.k = int'($urandom_range(0, 3)); v.to = 1'b0;
      v.exp_rdata = v.wr ? 8'hFF : v.din;
      v.exp_lat = (v.io ? 105 : 75) + CLK_DIV * v.k;
      run_txn(100 + i, v);
    end

    // Reset during T2 of a memory write
    BUS_WAIT_n = 1'b1;
    wait_ready("ready_before_reset_txn");
    REQ_WRITE = 1'b1; REQ_IO = 1'b0; REQ_SLOT = 1'b1;
    REQ_ADDR = 16'hA5A5; REQ_WDATA = 8'h3C; REQ_VALID = 1'b1;
    @(posedge CLK_BASE);
    #1;
    acc = int'(cyc);
    s = (acc / CLK_DIV + 1) * CLK_DIV;
    @(negedge CLK_BASE);
    REQ_VALID = 1'b0;
    guard = 0;
    while (int'(cyc) - s < 50 && guard < 200) begin
      @(negedge CLK_BASE);
      guard++;
    end
    chk("wr_low_in_t2", {BUS_WR_n, BUS_D_OE, BUS_MREQ_n}, 3'b010);
    #3 RESET_n = 1'b0;
    #1 chk("reset_async_release", {act_ctrl(), BUS_A}, {(9'b0_11111_0_0_0 | {BUS_CLOCK, 8'h00}), 16'h0000});
    repeat (3) @(negedge CLK_BASE);
    RESET_n = 1'b1;
    last_addr = '0;
    @(negedge CLK_BASE);
    chk("ready_after_reset", REQ_READY, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK_BASE);
      if (RSP_VALID || !BUS_MREQ_n || !BUS_WR_n || BUS_D_OE) seen = 1'b1;
    end
    chk("no_activity_after_reset", seen, 1'b0);

    run_txn(200, tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
